// File: rtl/rr_priority_pick.sv
// Rotated priority search: returns the first set request at or after ptr,
// wrapping modulo N, as a one-hot vector plus its binary index.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    winner,
  output logic [IdxW-1:0] idx,
  output logic            found
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             sum;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over a window starting at ptr.
  always_comb begin
    dbl    = {req, req};
    rot    = dbl[ptr +: N];
    found  = 1'b0;
    idx    = '0;
    sum    = 0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= N) sum = sum - N;
        idx   = IdxW'(sum);
      end
    end
    for (int i = 0; i < N; i++) begin
      winner[i] = found && (idx == IdxW'(i));
    end
  end

endmodule

// File: rtl/rr_arbiter_one_hot.sv
// Round-robin valid/ready arbiter with packet locking; emits the one-hot
// select for a downstream flat mux plus the merged consumer handshake.
module rr_arbiter_one_hot #(
  parameter int NumInputs = 4,
  localparam int IdxWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumInputs-1:0] valid_i,
  input  logic [NumInputs-1:0] last_i,
  output logic [NumInputs-1:0] ready_o,
  output logic [NumInputs-1:0] grant_o,
  output logic [IdxWidth-1:0]  grant_idx_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 ready_i
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [NumInputs-1:0]   grant_q, grant_d;
  logic [NumInputs-1:0]   pick_grant;
  logic [IdxWidth-1:0]    pick_idx;
  logic                   pick_found;
  logic                   handshake;
  int                     ptr_next;

  rr_priority_pick #(
    .N    (NumInputs),
    .IdxW (IdxWidth)
  ) u_pick (
    .req    (valid_i),
    .ptr    (ptr_q),
    .winner (pick_grant),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    if (!rst_i) begin
      if (state_q == LOCKED) begin
        grant_o = grant_q;
        valid_o = |(valid_i & grant_q);
      end else begin
        grant_o = pick_grant;
        valid_o = |valid_i;
      end
    end
    for (int i = 0; i < NumInputs; i++) begin
      if (grant_o[i]) grant_idx_o = grant_idx_o | IdxWidth'(i);
    end
    ready_o   = grant_o & {NumInputs{ready_i}};
    last_o    = |(last_i & grant_o);
    handshake = valid_o & ready_i;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    ptr_next = int'(grant_idx_o) + 1;
    if (ptr_next >= NumInputs) ptr_next = 0;
    if (handshake && last_o) begin
      state_d = IDLE;
      ptr_d   = IdxWidth'(ptr_next);
      grant_d = '0;
    end else if (grant_o != '0) begin
      // Hold the grant across backpressure and mid-packet gaps.
      state_d = LOCKED;
      grant_d = grant_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifndef SYNTHESIS
  logic                 stall_q;
  logic [NumInputs-1:0] prev_grant_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q      <= 1'b0;
      prev_grant_q <= '0;
    end else begin
      assert ($onehot0(grant_o)) else $error("grant_o not one-hot");
      assert ((ready_o & ~grant_o) == '0) else $error("ready_o outside grant_o");
      if (stall_q) assert (grant_o == prev_grant_q) else $error("grant_o changed while stalled");
      stall_q      <= valid_o & ~ready_i;
      prev_grant_q <= grant_o;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_one_hot.sv
// Directed bench for rr_arbiter_one_hot: reset gating, fairness, backpressure,
// packet locking, mid-packet gaps and reset abort.
module tb_rr_arbiter_one_hot;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid;
  logic [3:0] last;
  logic [3:0] ready_o;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       valid_o;
  logic       last_o;
  logic       ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_one_hot #(.NumInputs(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .last_i      (last),
    .ready_o     (ready_o),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .ready_i     (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; valid = '0; last = '0; ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 4'b1111; last = 4'b1111; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || ready_o !== 4'b0000 || valid_o !== 1'b0 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate: grant=%b ready_o=%b valid_o=%b last_o=%b required 0000 0000 0 0",
               grant, ready_o, valid_o, last_o);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: grant=%b idx=%0d required 0001 0", grant, grant_idx);
    end
    $display("test_reset: grant=%b idx=%0d after release", grant, grant_idx);
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    valid = 4'b1111; last = 4'b1111; ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== exp_g[c] || grant_idx !== exp_i[c] || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL fairness cycle %0d: grant=%b idx=%0d valid_o=%b required %b %0d 1",
                 c, grant, grant_idx, valid_o, exp_g[c], exp_i[c]);
      end
      $display("test_fairness cycle %0d: grant=%b", c, grant);
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    valid = 4'b0100; last = 4'b0100; ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) valid = 4'b0101;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100 || valid_o !== 1'b1 || ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: grant=%b valid_o=%b ready_o=%b required 0100 1 0000",
                 c, grant, valid_o, ready_o);
      end
      $display("test_backpressure stall %0d: grant=%b", c, grant);
      tick();
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 4'b0100 || last_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: ready_o=%b last_o=%b required 0100 1", ready_o, last_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL bp_wrap: grant=%b idx=%0d required 0001 0", grant, grant_idx);
    end
    $display("test_backpressure after accept: grant=%b", grant);
    tick();
  endtask

  task automatic test_packet_lock();
    apply_reset();
    valid = 4'b0001; last = 4'b0001; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL pkt_prime: grant=%b required 0001", grant);
    end
    tick();
    valid = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      last = (b == 2) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || last_o !== (b == 2)) begin
        errors++;
        $display("FAIL pkt_beat %0d: grant=%b last_o=%b required 0010 %0d", b, grant, last_o, (b == 2));
      end
      $display("test_packet_lock beat %0d: grant=%b last_o=%b", b, grant, last_o);
      tick();
    end
    last = 4'b0000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL pkt_next: grant=%b required 0001", grant);
    end
    tick();
  endtask

  task automatic test_gap();
    apply_reset();
    valid = 4'b1000; last = 4'b0000; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000 || ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL gap_first: grant=%b ready_o=%b required 1000 1000", grant, ready_o);
    end
    tick();
    valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b1000 || valid_o !== 1'b0 || ready_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold cycle %0d: grant=%b valid_o=%b ready_o=%b required 1000 0 bit0=0",
                 c, grant, valid_o, ready_o);
      end
      $display("test_gap idle %0d: grant=%b valid_o=%b", c, grant, valid_o);
      tick();
    end
    valid = 4'b1001; last = 4'b1000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000 || valid_o !== 1'b1 || last_o !== 1'b1) begin
      errors++;
      $display("FAIL gap_resume: grant=%b valid_o=%b last_o=%b required 1000 1 1", grant, valid_o, last_o);
    end
    tick();
    last = 4'b0000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL gap_next: grant=%b required 0001", grant);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    valid = 4'b1000; last = 4'b0000; ready = 1'b0;
    tick();
    valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL rmp_locked: grant=%b required 1000", grant);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rmp_in_reset: grant=%b valid_o=%b required 0000 0", grant, valid_o);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL rmp_after: grant=%b idx=%0d required 0001 0", grant, grant_idx);
    end
    $display("test_reset_mid_packet after reset: grant=%b", grant);
    tick();
  endtask

  initial begin
    rst = 1'b1; valid = '0; last = '0; ready = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_packet_lock();
    test_gap();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_one_hot.md
Name: rr_arbiter_one_hot

Overview:
- Round-robin arbiter for NumInputs valid/ready requesters with optional multi-beat packet locking.
- Produces the one-hot grant that drives the select of the downstream flat one-hot mux, plus the shared valid/ready handshake toward the consumer.
- Sits directly upstream of that mux. Payload never passes through this block; the mux selects data_i slices using grant_o.

Parameters:
- NumInputs, 4, number of requesters; legal range >= 1.
- IdxWidth, (NumInputs > 1) ? $clog2(NumInputs) : 1, width of the binary grant index. Derived; not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  NumInputs  per-requester valid.
- last_i  in  NumInputs  per-requester last-beat flag. Sampled only with the granted valid.
- ready_o  out  NumInputs  per-requester ready; at most one bit set.
- grant_o  out  NumInputs  one-hot (or zero) grant; drives the mux sel_i.
- grant_idx_o  out  IdxWidth  binary index of grant_o; 0 when grant_o == 0.
- valid_o  out  1  merged valid toward consumer.
- last_o  out  1  last_i of the granted requester.
- ready_i  in  1  consumer ready.

Behaviour:
- State registers:
  - state_q in {IDLE, LOCKED}.
  - ptr_q (IdxWidth), the highest-priority index.
  - grant_q (NumInputs).
- Reset (rst_i high at a clock edge): state_q=IDLE, ptr_q=0, grant_q=0.
- While rst_i is high, grant_o, grant_idx_o, ready_o, valid_o and last_o are forced to 0 combinationally.
- IDLE:
  - Winner = first set bit of valid_i, searching ptr_q, ptr_q+1, ... wrapping modulo NumInputs.
  - grant_o = winner one-hot in the same cycle (zero-latency). grant_o=0 if valid_i==0.
  - valid_o = |valid_i.
- LOCKED:
  - grant_o = grant_q.
  - valid_o = |(valid_i & grant_q).
  - New requests are ignored. No preemption, even if the granted valid drops mid-packet (valid_o=0, grant held).
- All states:
  - ready_o = grant_o & {NumInputs{ready_i}}.
  - last_o = |(last_i & grant_o).
  - Handshake = valid_o & ready_i.
- Transitions:
  - Handshake with last_o=1: next state_q=IDLE, ptr_q <= (granted index + 1) mod NumInputs, grant_q <= 0.
  - Handshake with last_o=0, or grant_o!=0 without a handshake: state_q=LOCKED, grant_q <= grant_o, ptr_q unchanged.
    - This keeps the grant stable under backpressure, as the stable-valid/data handshake rule requires.
  - Otherwise: state unchanged.
- Single-beat traffic (last_i tied high) yields one grant per accepted beat; back-to-back grants switch every cycle with no bubble.
- NumInputs==1: ptr_q is constant 0; grant_o=valid_i in IDLE.
- Invariants (assert in RTL, synthesis-off):
  - grant_o is one-hot or zero.
  - ready_o is a subset of grant_o.
  - grant_o stable while valid_o & !ready_i.
- Reset mid-packet aborts the lock. No partial-packet recovery; the requester must restart.

Decomposition:
- No shared package entries. The state enum and IdxWidth are local to the module.
- One combinational sub-module, rr_priority_pick (req, ptr -> one-hot winner, index).
  - Implemented as a double-width rotated priority search.
  - Reusable by other arbiters in utils.

Test Plan:
1. Reset gating: rst_i=1, valid_i=4'b1111, ready_i=1 -> grant_o=0, ready_o=0, valid_o=0. First cycle after release -> grant_o=4'b0001, grant_idx_o=0.
2. Fairness: valid_i=4'b1111, last_i=4'b1111, ready_i=1 continuous -> grant_o sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, valid_o=1 throughout.
3. Backpressure lock: valid_i=4'b0100, ready_i=0 for 3 cycles; bit0 raised on cycle 2 -> grant_o=0100 held for all 3 cycles. Then ready_i=1 with last=1 -> accept from req2; next cycle grant_o=0001 (ptr wrapped from 3).
4. Packet lock: req1 sends 3 beats (last_i[1] on 3rd), req0 valid throughout, ready_i=1 -> grant_o=0010 for 3 cycles, then 0001. last_o=1 only on the 3rd beat.
5. Gap in packet: req3 locked after beat 1 (last=0), valid_i[3] drops 2 cycles while valid_i[0]=1 -> valid_o=0, grant_o stays 1000, ready_o[0]=0. Resume -> last beat accepted, then grant_o=0001.
6. Reset mid-packet: LOCKED on req3, rst_i pulsed 1 cycle, then valid_i=4'b1001 -> grant_o=0001 (ptr_q reset to 0).
